// File: rtl/gpio_in_ctl_pkg.sv
// rtl/gpio_in_ctl_pkg.sv - shared register map and bus constants for the GPIO input controller
package gpio_defs;

    localparam int BUS_W = 32;

    localparam logic [2:0] GPIO_DATA = 3'd0;
    localparam logic [2:0] GPIO_RISE = 3'd1;
    localparam logic [2:0] GPIO_FALL = 3'd2;
    localparam logic [2:0] GPIO_PEND = 3'd3;
    localparam logic [2:0] GPIO_DBNC = 3'd4;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/gpio_in_ctl_if.sv
// rtl/gpio_in_ctl_if.sv - register bus between the CPU side and the GPIO input controller
interface gpio_in_ctl_if;
    import gpio_defs::*;

    logic             i_stb;
    logic             i_rw;
    logic [2:0]       i_addr;
    logic [BUS_W-1:0] i_dtw;
    logic [BUS_W-1:0] o_dtr;
    logic             o_ack;

    modport master (
        output i_stb, i_rw, i_addr, i_dtw,
        input  o_dtr, o_ack
    );

    modport slave (
        input  i_stb, i_rw, i_addr, i_dtw,
        output o_dtr, o_ack
    );

endinterface

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-pin two-flop synchronizer and debounce counter
// changed_o is high in the cycle whose closing edge updates state_o; dir_o is the new level.
module gpio_debounce #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pin_i,
    input  logic [CW-1:0] dbreg_i,
    output logic          state_o,
    output logic          changed_o,
    output logic          dir_o
);

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic          state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == dbreg_i) begin
            state_d = sync2_q;
            cnt_d   = '0;
        end else begin
            // A counter left above a freshly lowered dbreg wraps before matching.
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o   = state_q;
    assign changed_o = (sync2_q != state_q) && (cnt_q == dbreg_i);
    assign dir_o     = sync2_q;

endmodule

// File: rtl/gpio_in_ctl.sv
// rtl/gpio_in_ctl.sv - GPIO input controller: debounced pins, edge-to-pending latch, register file
module gpio_in_ctl
    import gpio_defs::*;
#(
    parameter int NPINS = 9,
    parameter int CW    = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NPINS-1:0] i_pins,
    gpio_in_ctl_if.slave     bus,
    output logic             o_irq
);

    logic [NPINS-1:0] state_w;
    logic [NPINS-1:0] changed_w;
    logic [NPINS-1:0] dir_w;
    logic [NPINS-1:0] set_w;
    logic [NPINS-1:0] clr_w;
    logic [NPINS-1:0] pending_d;
    logic [NPINS-1:0] pending_q;
    logic [NPINS-1:0] rise_en_q;
    logic [NPINS-1:0] fall_en_q;
    logic [CW-1:0]    dbreg_q;
    logic [BUS_W-1:0] rdata_w;
    logic [BUS_W-1:0] dtr_q;
    logic             ack_q;
    logic             irq_q;
    logic             access_w;
    logic             wr_w;
    bus_state_e       bus_q;

    for (genvar g = 0; g < NPINS; g++) begin : g_pin
        gpio_debounce #(.CW(CW)) u_dbnc (
            .clk_i     (CLK),
            .rst_ni    (RST_N),
            .pin_i     (i_pins[g]),
            .dbreg_i   (dbreg_q),
            .state_o   (state_w[g]),
            .changed_o (changed_w[g]),
            .dir_o     (dir_w[g])
        );
    end

    assign access_w = (bus_q == BUS_IDLE) && bus.i_stb;
    assign wr_w     = access_w && bus.i_rw;

    always_comb begin
        rdata_w = '0;
        case (bus.i_addr)
            GPIO_DATA: rdata_w = BUS_W'(state_w);
            GPIO_RISE: rdata_w = BUS_W'(rise_en_q);
            GPIO_FALL: rdata_w = BUS_W'(fall_en_q);
            GPIO_PEND: rdata_w = BUS_W'(pending_q);
            GPIO_DBNC: rdata_w = BUS_W'(dbreg_q);
            default:   rdata_w = '0;
        endcase
    end

    // Set has priority over a simultaneous write-1-to-clear.
    always_comb begin
        set_w     = changed_w & ((dir_w & rise_en_q) | (~dir_w & fall_en_q));
        clr_w     = (wr_w && (bus.i_addr == GPIO_PEND)) ? NPINS'(bus.i_dtw) : '0;
        pending_d = (pending_q & ~clr_w) | set_w;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus_q     <= BUS_IDLE;
            ack_q     <= 1'b0;
            dtr_q     <= '0;
            irq_q     <= 1'b0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            dbreg_q   <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= |pending_q;
            case (bus_q)
                BUS_IDLE: begin
                    if (bus.i_stb) begin
                        bus_q <= BUS_ACK;
                        ack_q <= 1'b1;
                        dtr_q <= rdata_w;
                        if (bus.i_rw) begin
                            case (bus.i_addr)
                                GPIO_RISE: rise_en_q <= NPINS'(bus.i_dtw);
                                GPIO_FALL: fall_en_q <= NPINS'(bus.i_dtw);
                                GPIO_DBNC: dbreg_q   <= CW'(bus.i_dtw);
                                default:   ;
                            endcase
                        end
                    end
                end
                BUS_ACK: begin
                    bus_q <= BUS_IDLE;
                    ack_q <= 1'b0;
                    dtr_q <= '0;
                end
                default: begin
                    bus_q <= BUS_IDLE;
                    ack_q <= 1'b0;
                    dtr_q <= '0;
                end
            endcase
        end
    end

    assign bus.o_ack = ack_q;
    assign bus.o_dtr = dtr_q;
    assign o_irq     = irq_q;

endmodule

// File: doc/gpio_in_ctl.md
# gpio_in_ctl

Input-side GPIO controller for the SoC: the receiving end of the GPIO pins that the SoC top drives and that benches observe. It synchronizes and debounces up to `NPINS` external pins, detects enabled rising/falling edges, and latches them into pending-interrupt bits. The CPU reads pin state and services interrupts through a small register file on the SoC bus.

## Interface
Parameters:
- `NPINS`, 9: number of input pins; legal range 1..32.
- `CW`, 8: debounce counter width, in bits.

Ports:
- `CLK`  in  1  system clock.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `i_pins`  in  NPINS  raw external pins; asynchronous to `CLK`.
- `i_stb`  in  1  bus request strobe; held until `o_ack`.
- `i_rw`  in  1  1 = write, 0 = read.
- `i_addr`  in  3  word address.
- `i_dtw`  in  32  write data.
- `o_dtr`  out  32  read data; valid while `o_ack` = 1.
- `o_ack`  out  1  one-cycle transfer acknowledge.
- `o_irq`  out  1  level interrupt; 1 when any pending bit is set.

## Operation
- Sync: a two-flop synchronizer per pin produces `sync`.
- Debounce: each pin has a counter `cnt[CW-1:0]` and a debounced bit `state`. On each cycle:
  - If `sync == state`, `cnt` is set to 0.
  - Else if `cnt == dbreg`, `state` takes `sync` and `cnt` is set to 0.
  - Else `cnt` increments.
  - `dbreg` = 0 means `state` follows `sync` with a 1-cycle delay.
- Edge detect: on the cycle `state` updates, the pin's pending bit is set if the change is 0→1 and `RISE_EN[i]` = 1, or 1→0 and `FALL_EN[i]` = 1.
- Register map (word address):
  - 0 DATA: RO, `state`.
  - 1 RISE_EN: RW.
  - 2 FALL_EN: RW.
  - 3 PENDING: RO bits, write-1-to-clear.
  - 4 DEBOUNCE: RW, low `CW` bits = `dbreg`.
  - 5..7: read 0, writes ignored.
  - All unused upper bits read 0.
- Bus handshake:
  - `i_stb` high with `o_ack` low: the access is performed, and `o_ack` is asserted on the next cycle with `o_dtr` valid.
  - `o_ack` is forced low the cycle after any ack, so a held `i_stb` produces one access every 2 cycles.
  - Write data takes effect in the ack cycle.
- Simultaneous W1C clear and a new edge on the same bit: set wins; the bit stays 1.
- Writing DEBOUNCE mid-count: the new `dbreg` applies from the next cycle. A counter already greater than the new value reaches the update condition only after wrapping. Software must write DEBOUNCE while the pins are quiet.

## Timing
- Reset values:
  - `o_ack` = 0, `o_dtr` = 0, `o_irq` = 0.
  - All registers and counters = 0; synchronizer flops and `state` = 0.
- Latency:
  - Pin edge to `state`: 2 cycles (sync) + `dbreg` + 1 cycles.
  - `state` update to PENDING bit set: the same clock edge.
  - PENDING to `o_irq`: 1 cycle; `o_irq` is registered.
- Bus latency: 1 cycle from `i_stb` to `o_ack`.
- DATA read: returns `state` as of the cycle `i_stb` was sampled.
- `RST_N` asserted mid-transfer:
  - `o_ack` drops immediately and the transfer is lost.
  - Pins that are high at reset release register a 0→1 change after sync and debounce; this sets pending only if RISE_EN is enabled, and it is 0 after reset.

## Structure
- A shared package `gpio_defs` holds the register address constants (`GPIO_DATA` = 0 … `GPIO_DBNC` = 4) and the bus word width of 32.
- One sub-module, `gpio_debounce`: a single-pin synchronizer, counter and `state` with a `changed`/`dir` output. It is instantiated `NPINS` times in a generate loop.
- Register file, edge-to-pending logic and bus FSM (IDLE → ACK → IDLE) live in the top module.

## Test plan
1. Reset release with `i_pins` = 0 → `o_ack`/`o_irq`/`o_dtr` = 0; reads of all addresses 0..7 return 0.
2. DEBOUNCE = 3, pin 2 raised and held → DATA reads 0x004 once 2+4 cycles have elapsed after the edge, not earlier. A 3-cycle glitch on pin 2 → DATA is unchanged.
3. RISE_EN = 0x001, FALL_EN = 0x100, DEBOUNCE = 0; pulse pin 0 high, then pin 8 high then low → PENDING = 0x101 and `o_irq` = 1. Write PENDING = 0x001 → PENDING = 0x100 and `o_irq` stays 1. Write 0x100 → `o_irq` = 0 one cycle later.
4. W1C of bit 0 in the same cycle as a new rising edge on pin 0 → PENDING[0] stays 1.
5. `i_stb` held for 6 cycles on a DATA read → exactly 3 `o_ack` pulses, each 1 cycle wide. A write to address 6 followed by a read of it → 0.
6. Assert `RST_N` low during an ack cycle with PENDING = 0x1FF → all outputs are 0 immediately, and PENDING = 0 after release.
